// File: rtl/fcmp_pkg.sv
// Shared types and helpers for the FloPoCo floating-point comparator:
// exception codes, predicate encoding, operand class flags and predicate evaluation.
package fcmp_pkg;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  typedef enum logic [2:0] {
    MODE_EQ    = 3'd0,
    MODE_LT    = 3'd1,
    MODE_LE    = 3'd2,
    MODE_GT    = 3'd3,
    MODE_GE    = 3'd4,
    MODE_NE    = 3'd5,
    MODE_UNORD = 3'd6,
    MODE_ORD   = 3'd7
  } fcmp_mode_t;

  typedef struct packed {
    logic zero;
    logic norm;
    logic inf;
    logic nan;
    logic sign;
  } fcmp_class_t;

  function automatic fcmp_class_t fcmp_decode(input logic [1:0] exc, input logic sign);
    fcmp_class_t c;
    c.zero = (exc == EXC_ZERO);
    c.norm = (exc == EXC_NORM);
    c.inf  = (exc == EXC_INF);
    c.nan  = (exc == EXC_NAN);
    c.sign = sign;
    return c;
  endfunction

  // Position on the number line: -inf, -normal, zero, +normal, +inf.
  function automatic logic [2:0] fcmp_rank(input fcmp_class_t c);
    logic [2:0] r;
    r = 3'd2;
    if (c.inf)
      r = c.sign ? 3'd0 : 3'd4;
    else if (c.norm)
      r = c.sign ? 3'd1 : 3'd3;
    return r;
  endfunction

  function automatic logic fcmp_is_rel(input fcmp_mode_t m);
    return (m == MODE_LT) || (m == MODE_LE) || (m == MODE_GT) || (m == MODE_GE);
  endfunction

  function automatic logic fcmp_select(input fcmp_class_t cx, input fcmp_class_t cy,
                                       input logic mlt, input logic meq, input logic mgt,
                                       input fcmp_mode_t m);
    logic u, lt, eq, gt, r;
    logic [2:0] rx, ry;
    u  = cx.nan | cy.nan;
    rx = fcmp_rank(cx);
    ry = fcmp_rank(cy);
    lt = 1'b0;
    eq = 1'b0;
    gt = 1'b0;
    r  = 1'b0;
    if (rx != ry) begin
      lt = (rx < ry);
      gt = (rx > ry);
    end else if (cx.norm) begin
      // Same rank and normal means same sign; negatives invert magnitude order.
      lt = cx.sign ? mgt : mlt;
      gt = cx.sign ? mlt : mgt;
      eq = meq;
    end else begin
      eq = 1'b1;
    end
    case (m)
      MODE_EQ:    r = !u && eq;
      MODE_LT:    r = !u && lt;
      MODE_LE:    r = !u && (lt || eq);
      MODE_GT:    r = !u && gt;
      MODE_GE:    r = !u && (gt || eq);
      MODE_NE:    r = u || !eq;
      MODE_UNORD: r = u;
      default:    r = !u;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fcmp_mag_cmp.sv
// Combinational unsigned magnitude comparator.
module fcmp_mag_cmp #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/fcmp_pipe.sv
// Elastic pipelined floating-point comparator with runtime predicate select
// and a sticky invalid-operation flag.
module fcmp_pipe
  import fcmp_pkg::*;
#(
  parameter int WE     = 4,
  parameter int WF     = 10,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WE+WF+2:0]  x,
  input  logic [WE+WF+2:0]  y,
  input  logic [2:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              result,
  output logic              unordered,
  input  logic              clr_sticky,
  output logic              invalid_sticky
);

  localparam int W = WE + WF + 3;
  localparam int M = WE + WF;
  localparam int H = (M + 1) / 2;
  localparam int L = M - H;

  fcmp_class_t cx, cy;
  fcmp_mode_t  mode_in;
  assign cx      = fcmp_decode(x[W-1:W-2], x[W-3]);
  assign cy      = fcmp_decode(y[W-1:W-2], y[W-3]);
  assign mode_in = fcmp_mode_t'(mode);

  logic [STAGES-1:0] vld_reg;
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] load;
  logic res_reg, unord_reg, inv_reg, sticky_reg;

  assign rdy[STAGES] = out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slice
      logic vsrc;
      if (gi == 0) begin : g_head
        assign vsrc = in_valid;
      end else begin : g_body
        assign vsrc = vld_reg[gi-1];
      end
      assign rdy[gi]  = !vld_reg[gi] || rdy[gi+1];
      assign load[gi] = rdy[gi] && vsrc;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          vld_reg[gi] <= 1'b0;
        else if (rdy[gi])
          vld_reg[gi] <= vsrc;
      end
    end

    if (STAGES == 1) begin : g_s1
      logic mlt, meq, mgt;
      fcmp_mag_cmp #(.N(M)) u_mag (.a(x[M-1:0]), .b(y[M-1:0]), .lt(mlt), .eq(meq), .gt(mgt));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_reg   <= 1'b0;
          unord_reg <= 1'b0;
          inv_reg   <= 1'b0;
        end else if (load[0]) begin
          res_reg   <= fcmp_select(cx, cy, mlt, meq, mgt, mode_in);
          unord_reg <= cx.nan | cy.nan;
          inv_reg   <= (cx.nan | cy.nan) & fcmp_is_rel(mode_in);
        end
      end
    end else if (STAGES == 2) begin : g_s2
      logic mlt, meq, mgt;
      fcmp_class_t cx0_reg, cy0_reg;
      logic lt0_reg, eq0_reg, gt0_reg;
      fcmp_mode_t mode0_reg;
      fcmp_mag_cmp #(.N(M)) u_mag (.a(x[M-1:0]), .b(y[M-1:0]), .lt(mlt), .eq(meq), .gt(mgt));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cx0_reg   <= '0;
          cy0_reg   <= '0;
          lt0_reg   <= 1'b0;
          eq0_reg   <= 1'b0;
          gt0_reg   <= 1'b0;
          mode0_reg <= MODE_EQ;
        end else if (load[0]) begin
          cx0_reg   <= cx;
          cy0_reg   <= cy;
          lt0_reg   <= mlt;
          eq0_reg   <= meq;
          gt0_reg   <= mgt;
          mode0_reg <= mode_in;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_reg   <= 1'b0;
          unord_reg <= 1'b0;
          inv_reg   <= 1'b0;
        end else if (load[1]) begin
          res_reg   <= fcmp_select(cx0_reg, cy0_reg, lt0_reg, eq0_reg, gt0_reg, mode0_reg);
          unord_reg <= cx0_reg.nan | cy0_reg.nan;
          inv_reg   <= (cx0_reg.nan | cy0_reg.nan) & fcmp_is_rel(mode0_reg);
        end
      end
    end else begin : g_s3
      logic hlt, heq, hgt, llt, leq, lgt;
      fcmp_class_t cx0_reg, cy0_reg, cx1_reg, cy1_reg;
      logic hlt0_reg, heq0_reg, hgt0_reg;
      logic [L-1:0] xlo0_reg, ylo0_reg;
      logic lt1_reg, eq1_reg, gt1_reg;
      fcmp_mode_t mode0_reg, mode1_reg;
      fcmp_mag_cmp #(.N(H)) u_hi (.a(x[M-1:L]), .b(y[M-1:L]), .lt(hlt), .eq(heq), .gt(hgt));
      fcmp_mag_cmp #(.N(L)) u_lo (.a(xlo0_reg), .b(ylo0_reg), .lt(llt), .eq(leq), .gt(lgt));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cx0_reg   <= '0;
          cy0_reg   <= '0;
          hlt0_reg  <= 1'b0;
          heq0_reg  <= 1'b0;
          hgt0_reg  <= 1'b0;
          xlo0_reg  <= '0;
          ylo0_reg  <= '0;
          mode0_reg <= MODE_EQ;
        end else if (load[0]) begin
          cx0_reg   <= cx;
          cy0_reg   <= cy;
          hlt0_reg  <= hlt;
          heq0_reg  <= heq;
          hgt0_reg  <= hgt;
          xlo0_reg  <= x[L-1:0];
          ylo0_reg  <= y[L-1:0];
          mode0_reg <= mode_in;
        end
      end

      // Upper half decides unless it ties; then the lower half breaks the tie.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cx1_reg   <= '0;
          cy1_reg   <= '0;
          lt1_reg   <= 1'b0;
          eq1_reg   <= 1'b0;
          gt1_reg   <= 1'b0;
          mode1_reg <= MODE_EQ;
        end else if (load[1]) begin
          cx1_reg   <= cx0_reg;
          cy1_reg   <= cy0_reg;
          lt1_reg   <= hlt0_reg | (heq0_reg & llt);
          eq1_reg   <= heq0_reg & leq;
          gt1_reg   <= hgt0_reg | (heq0_reg & lgt);
          mode1_reg <= mode0_reg;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_reg   <= 1'b0;
          unord_reg <= 1'b0;
          inv_reg   <= 1'b0;
        end else if (load[2]) begin
          res_reg   <= fcmp_select(cx1_reg, cy1_reg, lt1_reg, eq1_reg, gt1_reg, mode1_reg);
          unord_reg <= cx1_reg.nan | cy1_reg.nan;
          inv_reg   <= (cx1_reg.nan | cy1_reg.nan) & fcmp_is_rel(mode1_reg);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_reg <= 1'b0;
    else if (out_valid && out_ready && inv_reg)
      sticky_reg <= 1'b1;
    else if (clr_sticky)
      sticky_reg <= 1'b0;
  end

  assign in_ready       = rdy[0];
  assign out_valid      = vld_reg[STAGES-1];
  assign result         = res_reg;
  assign unordered      = unord_reg;
  assign invalid_sticky = sticky_reg;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: one instance per pipeline depth (1..3),
// selected at runtime, checked against a real-valued reference model.
module tb_fcmp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_sticky = 1'b0;
  logic [16:0] x = '0;
  logic [16:0] y = '0;
  logic [2:0]  mode = '0;
  logic [1:0]  sel = 2'd1;

  logic [2:0] iv_a, in_ready_a, out_valid_a, result_a, unordered_a, sticky_a;
  logic in_ready, out_valid, result, unordered, invalid_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      assign iv_a[gi] = in_valid && (sel == 2'(gi));
      fcmp_pipe #(.WE(4), .WF(10), .STAGES(gi + 1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv_a[gi]), .in_ready(in_ready_a[gi]),
        .x(x), .y(y), .mode(mode),
        .out_valid(out_valid_a[gi]), .out_ready(out_ready),
        .result(result_a[gi]), .unordered(unordered_a[gi]),
        .clr_sticky(clr_sticky), .invalid_sticky(sticky_a[gi])
      );
    end
  endgenerate

  assign in_ready       = in_ready_a[sel];
  assign out_valid      = out_valid_a[sel];
  assign result         = result_a[sel];
  assign unordered      = unordered_a[sel];
  assign invalid_sticky = sticky_a[sel];

  // Reference: map operands onto the real line (exponent bias is irrelevant to order).
  function automatic real enc_val(input logic [16:0] v);
    real m, s;
    m = 0.0;
    if (v[16:15] == 2'b10) begin
      m = 1.0e30;
    end else if (v[16:15] == 2'b01) begin
      s = 1.0;
      for (int i = 0; i < int'(v[13:10]); i++) s = s * 2.0;
      m = (1.0 + real'(v[9:0]) / 1024.0) * s;
    end
    return v[14] ? -m : m;
  endfunction

  function automatic logic [1:0] ref_cmp(input logic [16:0] a, input logic [16:0] b,
                                         input logic [2:0] m);
    logic u, r;
    real ra, rb;
    u = (a[16:15] == 2'b11) || (b[16:15] == 2'b11);
    r = 1'b0;
    if (u) begin
      r = (m == 3'd5) || (m == 3'd6);
    end else begin
      ra = enc_val(a);
      rb = enc_val(b);
      case (m)
        3'd0: r = (ra == rb);
        3'd1: r = (ra < rb);
        3'd2: r = (ra <= rb);
        3'd3: r = (ra > rb);
        3'd4: r = (ra >= rb);
        3'd5: r = (ra != rb);
        3'd6: r = 1'b0;
        default: r = 1'b1;
      endcase
    end
    return {r, u};
  endfunction

  function automatic logic [16:0] rnd_op();
    logic [16:0] v;
    v = 17'($urandom);
    if ($urandom_range(0, 2) != 0) v[16:15] = 2'b01;
    if ($urandom_range(0, 1) == 0) v[9:0] = 10'($urandom_range(0, 3));
    return v;
  endfunction

  function automatic logic [16:0] rnd_peer(input logic [16:0] a);
    logic [16:0] v;
    case ($urandom_range(0, 3))
      0: v = a;
      1: v = a ^ 17'h04000;
      2: begin v = a; v[1:0] = 2'($urandom); end
      default: v = rnd_op();
    endcase
    return v;
  endfunction

  task automatic send_one(input logic [16:0] a, input logic [16:0] b, input logic [2:0] m,
                          output logic r, output logic u, output int lat);
    int k;
    @(negedge clk);
    x = a; y = b; mode = m; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk); #1; k++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk); lat++;
    end
    r = result;
    u = unordered;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++; if (out_valid_a !== 3'b000) begin n_fail++; $display("FAIL reset_out_valid got=%b want=000", out_valid_a); end
    n_tests++; if (result_a !== 3'b000) begin n_fail++; $display("FAIL reset_result got=%b want=000", result_a); end
    n_tests++; if (unordered_a !== 3'b000) begin n_fail++; $display("FAIL reset_unordered got=%b want=000", unordered_a); end
    n_tests++; if (sticky_a !== 3'b000) begin n_fail++; $display("FAIL reset_sticky got=%b want=000", sticky_a); end
    n_tests++; if (in_ready_a !== 3'b111) begin n_fail++; $display("FAIL reset_in_ready got=%b want=111", in_ready_a); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset: outputs checked on all depths");
  endtask

  task automatic test_latency();
    logic r, u;
    int lat;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      send_one(17'h09C00, 17'h0A000, 3'd1, r, u, lat);
      n_tests++; if (lat != s + 1) begin n_fail++; $display("FAIL latency_s%0d got=%0d want=%0d", s + 1, lat, s + 1); end
      n_tests++; if (r !== 1'b1 || u !== 1'b0) begin n_fail++; $display("FAIL basic_lt_s%0d got=%b%b want=10", s + 1, r, u); end
      $display("[TB] latency stages=%0d lat=%0d result=%b", s + 1, lat, r);
    end
  endtask

  task automatic test_directed();
    logic [16:0] ta [14] = '{17'h09C00, 17'h09C00, 17'h0DC00, 17'h04000, 17'h04000, 17'h14000,
                             17'h10000, 17'h0A000, 17'h0DC00, 17'h0E000, 17'h18000, 17'h18000,
                             17'h09C00, 17'h18000};
    logic [16:0] tb_ [14] = '{17'h0A000, 17'h0A000, 17'h0A000, 17'h00000, 17'h00000, 17'h14000,
                              17'h10000, 17'h10000, 17'h0DC00, 17'h0DC00, 17'h09C00, 17'h09C00,
                              17'h18000, 17'h18000};
    logic [2:0] tm [14] = '{3'd1, 3'd4, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd0, 3'd1,
                            3'd5, 3'd7, 3'd6, 3'd0};
    logic [1:0] te [14] = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10,
                            2'b11, 2'b01, 2'b11, 2'b01};
    logic r, u;
    int lat;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      for (int i = 0; i < 14; i++) begin
        send_one(ta[i], tb_[i], tm[i], r, u, lat);
        n_tests++;
        if ({r, u} !== te[i]) begin
          n_fail++;
          $display("FAIL directed_s%0d_%0d x=%h y=%h mode=%0d got=%b%b want=%b", s + 1, i, ta[i], tb_[i], tm[i], r, u, te[i]);
        end
        $display("[TB] directed s=%0d x=%h y=%h mode=%0d result=%b unord=%b", s + 1, ta[i], tb_[i], tm[i], r, u);
      end
    end
  endtask

  task automatic test_sticky();
    logic r, u;
    int lat;
    sel = 2'd1;
    @(negedge clk); clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    n_tests++; if (invalid_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clear0 got=%b want=0", invalid_sticky); end
    send_one(17'h18000, 17'h09C00, 3'd5, r, u, lat);
    n_tests++; if ({r, u} !== 2'b11) begin n_fail++; $display("FAIL nan_ne got=%b%b want=11", r, u); end
    @(negedge clk);
    n_tests++; if (invalid_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_ne got=%b want=0", invalid_sticky); end
    send_one(17'h18000, 17'h09C00, 3'd2, r, u, lat);
    n_tests++; if ({r, u} !== 2'b01) begin n_fail++; $display("FAIL nan_le got=%b%b want=01", r, u); end
    n_tests++; if (invalid_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_pre_xfer got=%b want=0", invalid_sticky); end
    @(negedge clk);
    n_tests++; if (invalid_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_set got=%b want=1", invalid_sticky); end
    send_one(17'h18000, 17'h09C00, 3'd2, r, u, lat);
    clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    n_tests++; if (invalid_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins got=%b want=1", invalid_sticky); end
    @(negedge clk); clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    n_tests++; if (invalid_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clear got=%b want=0", invalid_sticky); end
    $display("[TB] sticky: ne/le/set-wins/clear sequence checked");
  endtask

  task automatic test_backpressure();
    logic [1:0] q[$];
    logic [1:0] exp_v;
    logic [16:0] ca, cb;
    logic [2:0] cm;
    int sent, got;
    bit saw_low, hold_v;
    logic hold_r, hold_u;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      q.delete();
      sent = 0; got = 0; saw_low = 0; hold_v = 0; hold_r = 0; hold_u = 0;
      ca = rnd_op(); cb = rnd_peer(ca); cm = 3'($urandom_range(0, 7));
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
        @(negedge clk);
        out_ready = !(cyc >= 3 && cyc <= 6);
        in_valid = (sent < 8);
        x = ca; y = cb; mode = cm;
        #1;
        if (!in_ready) saw_low = 1;
        if (hold_v) begin
          n_tests++;
          if (out_valid !== 1'b1 || result !== hold_r || unordered !== hold_u) begin
            n_fail++;
            $display("FAIL stall_hold_s%0d got=%b%b%b want=1%b%b", s + 1, out_valid, result, unordered, hold_r, hold_u);
          end
        end
        if (out_valid && out_ready) begin
          n_tests++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL stream_extra_s%0d got=%b%b want=none", s + 1, result, unordered);
          end else begin
            exp_v = q.pop_front();
            if ({result, unordered} !== exp_v) begin
              n_fail++;
              $display("FAIL stream_s%0d_%0d got=%b%b want=%b", s + 1, got, result, unordered, exp_v);
            end
          end
          $display("[TB] stream s=%0d idx=%0d result=%b unord=%b", s + 1, got, result, unordered);
          got++;
        end
        hold_v = out_valid && !out_ready;
        hold_r = result;
        hold_u = unordered;
        if (in_valid && in_ready) begin
          q.push_back(ref_cmp(ca, cb, cm));
          sent++;
          ca = rnd_op(); cb = rnd_peer(ca); cm = 3'($urandom_range(0, 7));
        end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      n_tests++; if (got != 8) begin n_fail++; $display("FAIL stream_count_s%0d got=%0d want=8", s + 1, got); end
      n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL stream_left_s%0d got=%0d want=0", s + 1, q.size()); end
      n_tests++; if (!saw_low) begin n_fail++; $display("FAIL in_ready_drop_s%0d got=0 want=1", s + 1); end
      repeat (4) @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_dup_s%0d got=%b want=0", s + 1, out_valid); end
    end
  endtask

  task automatic test_reset_midstream();
    logic r, u;
    int lat;
    sel = 2'd1;
    send_one(17'h18000, 17'h09C00, 3'd1, r, u, lat);
    @(negedge clk);
    x = 17'h09C00; y = 17'h0A000; mode = 3'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x = 17'h0A000; y = 17'h09C00; mode = 3'd3;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || invalid_sticky !== 1'b1) begin n_fail++; $display("FAIL pre_reset got=%b%b want=11", out_valid, invalid_sticky); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid got=%b want=0", out_valid); end
    n_tests++; if (invalid_sticky !== 1'b0) begin n_fail++; $display("FAIL async_reset_sticky got=%b want=0", invalid_sticky); end
    @(negedge clk);
    rst_n = 1'b1;
    send_one(17'h0DC00, 17'h0A000, 3'd1, r, u, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL post_reset_latency got=%0d want=2", lat); end
    n_tests++; if ({r, u} !== 2'b10) begin n_fail++; $display("FAIL post_reset_result got=%b%b want=10", r, u); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_flush got=%b want=0", out_valid); end
    $display("[TB] reset mid-stream: lat=%0d result=%b", lat, r);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_sticky();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
